// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl
// Purpose  : Input stage of the VGA paint design. Synchronises the raw
//            direction buttons, draw switch and colour switches, moves a
//            cursor over the framebuffer with a press / hold-repeat state
//            machine and issues single-cycle VRAM pixel write requests.
// Ports    : clk    - system clock
//            rst    - asynchronous, active-high reset
//            dir    - raw buttons [0] up, [1] down, [2] left, [3] right
//            draw   - raw draw switch
//            rgb    - raw 12-bit colour switches
//            cur_x  - cursor X position
//            cur_y  - cursor Y position
//            we     - VRAM write strobe (one clock per write)
//            waddr  - VRAM write address {cur_y, cur_x}
//            wdata  - VRAM write colour
// Options  : CURSOR_WRAP_EN - when defined the cursor wraps around the
//            framebuffer edges instead of saturating.
// Revision : 1.0 - initial release
// ============================================================================
module cursor_ctrl #(
   parameter int XW         = 8,
   parameter int YW         = 8,
   parameter int X_MAX      = 255,
   parameter int Y_MAX      = 255,
   parameter int X_RST      = 0,
   parameter int Y_RST      = 0,
   parameter int REPEAT_DLY = 8,
   parameter int STEP_DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       dir,
   input  logic             draw,
   input  logic [11:0]      rgb,
   output logic [XW-1:0]    cur_x,
   output logic [YW-1:0]    cur_y,
   output logic             we,
   output logic [XW+YW-1:0] waddr,
   output logic [11:0]      wdata
);

   // One counter serves both the initial delay and the repeat interval,
   // so it is sized for the larger of the two.
   localparam int            CNT_MAX    = (REPEAT_DLY > STEP_DIV) ? REPEAT_DLY : STEP_DIV;
   localparam int            CW         = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] C_DLY_LAST = CW'(REPEAT_DLY - 1);
   localparam logic [CW-1:0] C_DIV_LAST = CW'(STEP_DIV - 1);
   localparam logic [XW-1:0] C_X_MAX    = XW'(X_MAX);
   localparam logic [YW-1:0] C_Y_MAX    = YW'(Y_MAX);
   localparam logic [XW-1:0] C_X_RST    = XW'(X_RST);
   localparam logic [YW-1:0] C_Y_RST    = YW'(Y_RST);

`ifdef CURSOR_WRAP_EN
   localparam bit C_WRAP = 1'b1;
`else
   localparam bit C_WRAP = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [3:0]       dir_m_q,  dir_m_d;
   logic [3:0]       dir_s_q,  dir_s_d;
   logic [3:0]       dir_prev_q, dir_prev_d;
   logic             draw_m_q, draw_m_d;
   logic             draw_s_q, draw_s_d;
   logic             draw_prev_q, draw_prev_d;
   logic [11:0]      rgb_m_q,  rgb_m_d;
   logic [11:0]      rgb_s_q,  rgb_s_d;
   state_t           state_q,  state_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [XW-1:0]    cur_x_q,  cur_x_d;
   logic [YW-1:0]    cur_y_q,  cur_y_d;
   logic             we_q,     we_d;
   logic [XW+YW-1:0] waddr_q,  waddr_d;
   logic [11:0]      wdata_q,  wdata_d;

   logic             step;

   // ------------------------------------------------------------------------
   // Axis update: dec/inc together cancel; edges saturate or wrap.
   // ------------------------------------------------------------------------
   function automatic logic [XW-1:0] next_x(input logic [XW-1:0] v,
                                            input logic          dec,
                                            input logic          inc);
      logic [XW-1:0] r;
      r = v;
      if (dec && !inc) begin
         if (v == '0) r = C_WRAP ? C_X_MAX : v;
         else         r = v - 1'b1;
      end else if (inc && !dec) begin
         if (v >= C_X_MAX) r = C_WRAP ? '0 : C_X_MAX;
         else              r = v + 1'b1;
      end
      return r;
   endfunction

   function automatic logic [YW-1:0] next_y(input logic [YW-1:0] v,
                                            input logic          dec,
                                            input logic          inc);
      logic [YW-1:0] r;
      r = v;
      if (dec && !inc) begin
         if (v == '0) r = C_WRAP ? C_Y_MAX : v;
         else         r = v - 1'b1;
      end else if (inc && !dec) begin
         if (v >= C_Y_MAX) r = C_WRAP ? '0 : C_Y_MAX;
         else              r = v + 1'b1;
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // Two-flop synchronisers; everything downstream uses the *_s values.
      dir_m_d     = dir;
      dir_s_d     = dir_m_q;
      draw_m_d    = draw;
      draw_s_d    = draw_m_q;
      rgb_m_d     = rgb;
      rgb_s_d     = rgb_m_q;

      // Previous synchronised values, for press-change and rising-edge detect.
      dir_prev_d  = dir_s_q;
      draw_prev_d = draw_s_q;

      state_d     = state_q;
      cnt_d       = cnt_q;
      step        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dir_s_q != 4'd0) begin
               step    = 1'b1;
               state_d = S_DELAY;
               cnt_d   = '0;
            end
         end
         S_DELAY, S_REPEAT: begin
            if (dir_s_q == 4'd0) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (dir_s_q != dir_prev_q) begin
               // A different button combination restarts the press timing.
               step    = 1'b1;
               state_d = S_DELAY;
               cnt_d   = '0;
            end else if (state_q == S_DELAY) begin
               if (cnt_q == C_DLY_LAST) begin
                  step    = 1'b1;
                  state_d = S_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
               end
            end else begin
               if (cnt_q == C_DIV_LAST) begin
                  step    = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      if (step) begin
         cur_x_d = next_x(cur_x_q, dir_s_q[2], dir_s_q[3]);
         cur_y_d = next_y(cur_y_q, dir_s_q[0], dir_s_q[1]);
      end

      // A step while drawing (even a clamped one) or a draw rising edge
      // produces a single write; both in the same cycle still give one.
      we_d    = draw_s_q & (step | ~draw_prev_q);
      waddr_d = we_d ? {cur_y_d, cur_x_d} : waddr_q;
      wdata_d = we_d ? rgb_s_q : wdata_q;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_m_q     <= '0;
         dir_s_q     <= '0;
         dir_prev_q  <= '0;
         draw_m_q    <= 1'b0;
         draw_s_q    <= 1'b0;
         draw_prev_q <= 1'b0;
         rgb_m_q     <= '0;
         rgb_s_q     <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cur_x_q     <= C_X_RST;
         cur_y_q     <= C_Y_RST;
         we_q        <= 1'b0;
         waddr_q     <= {C_Y_RST, C_X_RST};
         wdata_q     <= '0;
      end else begin
         dir_m_q     <= dir_m_d;
         dir_s_q     <= dir_s_d;
         dir_prev_q  <= dir_prev_d;
         draw_m_q    <= draw_m_d;
         draw_s_q    <= draw_s_d;
         draw_prev_q <= draw_prev_d;
         rgb_m_q     <= rgb_m_d;
         rgb_s_q     <= rgb_s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign cur_x = cur_x_q;
   assign cur_y = cur_y_q;
   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_ctrl
// Purpose  : Self-checking bench for cursor_ctrl (default parameters).
//            Directed scenarios plus randomized stimulus compared against a
//            behavioural model based on how long a button combination has
//            been held. Honours CURSOR_WRAP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_ctrl;

   localparam int REPEAT_DLY = 8;
   localparam int STEP_DIV   = 4;
   localparam logic [7:0] X_MAX = 8'd255;
   localparam logic [7:0] Y_MAX = 8'd255;
`ifdef CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  dir = 4'd0;
   logic        draw = 1'b0;
   logic [11:0] rgb = 12'd0;
   logic [7:0]  cur_x, cur_y;
   logic        we;
   logic [15:0] waddr;
   logic [11:0] wdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cursor_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .dir   (dir),
      .draw  (draw),
      .rgb   (rgb),
      .cur_x (cur_x),
      .cur_y (cur_y),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata)
   );

   // ------------------------------------------------------------------------
   // Reference model: inputs are seen two clocks late; a step happens when a
   // new button combination appears, or after it has been held REPEAT_DLY
   // clocks, then every STEP_DIV clocks after that.
   // ------------------------------------------------------------------------
   logic [3:0]  m_dly [2];
   logic        m_drw [2];
   logic [11:0] m_col [2];
   logic [3:0]  m_last_dir;
   logic        m_last_draw;
   int          m_age;
   logic [7:0]  m_x, m_y;
   logic        m_we;
   logic [15:0] m_waddr;
   logic [11:0] m_wdata;

   int          mv_age;
   logic        mv_step;
   logic [7:0]  mv_x, mv_y;
   logic        mv_we;

   function automatic logic [7:0] m_axis(input logic [7:0] v, input logic dec,
                                         input logic inc, input logic [7:0] vmax);
      if (dec && !inc) return (v == 8'd0) ? (WRAP ? vmax : 8'd0) : v - 8'd1;
      if (inc && !dec) return (v == vmax) ? (WRAP ? 8'd0 : vmax) : v + 8'd1;
      return v;
   endfunction

   always_comb begin
      mv_age  = 0;
      mv_step = 1'b0;
      if (m_dly[1] != 4'd0) begin
         if (m_dly[1] != m_last_dir) begin
            mv_age  = 0;
            mv_step = 1'b1;
         end else begin
            mv_age  = m_age + 1;
            mv_step = (mv_age == REPEAT_DLY) ||
                      (mv_age > REPEAT_DLY && ((mv_age - REPEAT_DLY) % STEP_DIV) == 0);
         end
      end
      mv_x  = mv_step ? m_axis(m_x, m_dly[1][2], m_dly[1][3], X_MAX) : m_x;
      mv_y  = mv_step ? m_axis(m_y, m_dly[1][0], m_dly[1][1], Y_MAX) : m_y;
      mv_we = m_drw[1] && (mv_step || !m_last_draw);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dly[0] <= 4'd0;  m_dly[1] <= 4'd0;
         m_drw[0] <= 1'b0;  m_drw[1] <= 1'b0;
         m_col[0] <= 12'd0; m_col[1] <= 12'd0;
         m_last_dir  <= 4'd0;
         m_last_draw <= 1'b0;
         m_age   <= 0;
         m_x     <= 8'd0;
         m_y     <= 8'd0;
         m_we    <= 1'b0;
         m_waddr <= 16'd0;
         m_wdata <= 12'd0;
      end else begin
         m_dly[0] <= dir;  m_dly[1] <= m_dly[0];
         m_drw[0] <= draw; m_drw[1] <= m_drw[0];
         m_col[0] <= rgb;  m_col[1] <= m_col[0];
         m_last_dir  <= m_dly[1];
         m_last_draw <= m_drw[1];
         m_age   <= mv_age;
         m_x     <= mv_x;
         m_y     <= mv_y;
         m_we    <= mv_we;
         if (mv_we) begin
            m_waddr <= {mv_y, mv_x};
            m_wdata <= m_col[1];
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; dir = 4'd0; draw = 1'b0; rgb = 12'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [11:0] col;
      col = 12'($urandom);
      rst = 1'b1; dir = 4'b1000; draw = 1'b1; rgb = col;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({cur_x, cur_y, we, waddr, wdata} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got x=%h y=%h we=%b waddr=%h wdata=%h, required all zero",
                     cur_x, cur_y, we, waddr, wdata);
         end
      end
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         n_checks++;
         if (cur_x !== ((e >= 3) ? 8'd1 : 8'd0) || cur_y !== 8'd0 || we !== (e == 3)) begin
            n_fail++;
            $display("FAIL reset_release e=%0d: got x=%0d y=%0d we=%b, required x=%0d y=0 we=%b",
                     e, cur_x, cur_y, we, (e >= 3) ? 1 : 0, (e == 3));
         end
         if (e == 3) begin
            n_checks++;
            if (waddr !== 16'h0001 || wdata !== col) begin
               n_fail++;
               $display("FAIL reset_first_write: got waddr=%h wdata=%h, required 0001 %h",
                        waddr, wdata, col);
            end
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_hold_right();
      int ex;
      do_reset();
      dir = 4'b1000; draw = 1'b0;
      ex = 0;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         ex = (e < 3) ? 0 : (e < 11) ? 1 : 2 + (e - 11) / 4;
         n_checks++;
         if (cur_x !== 8'(ex) || cur_y !== 8'd0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_right e=%0d: got x=%0d y=%0d we=%b, required x=%0d y=0 we=0",
                     e, cur_x, cur_y, we, ex);
         end
      end
      dir = 4'd0;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         n_checks++;
         if (cur_x !== 8'd9 || we !== 1'b0 ||
             {cur_x, cur_y, we, waddr, wdata} !== {m_x, m_y, m_we, m_waddr, m_wdata}) begin
            n_fail++;
            $display("FAIL hold_release e=%0d: got x=%0d we=%b, required x=9 we=0", e, cur_x, we);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_clamp();
      int pulses;
      do_reset();
      dir = 4'b0101; draw = 1'b1; rgb = 12'($urandom);
      pulses = 0;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         if (we === 1'b1) pulses++;
         n_checks++;
         if (cur_x !== 8'd0 || cur_y !== 8'd0 || (we === 1'b1 && waddr !== 16'h0000)) begin
            n_fail++;
            $display("FAIL clamp e=%0d: got x=%0d y=%0d waddr=%h, required 0 0 0000",
                     e, cur_x, cur_y, waddr);
         end
      end
      n_checks++;
      if (pulses != 9) begin
         n_fail++;
         $display("FAIL clamp_pulses: got %0d write pulses, required 9", pulses);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_cancel();
      int exy;
      logic exw;
      do_reset();
      dir = 4'b1010; draw = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk);
         exy = (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : 3;
         exw = (e == 3) || (e == 11) || (e == 15) || (e == 16) || (e == 24) || (e == 28);
         n_checks++;
         if (cur_x !== 8'(exy) || cur_y !== 8'(exy) || we !== exw) begin
            n_fail++;
            $display("FAIL cancel e=%0d: got x=%0d y=%0d we=%b, required x=%0d y=%0d we=%b",
                     e, cur_x, cur_y, we, exy, exy, exw);
         end
         if (e == 13) dir = 4'b0011;
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_draw();
      int k;
      do_reset();
      dir = 4'b1010;
      repeat (15) @(negedge clk);
      dir = 4'd0;
      repeat (4) @(negedge clk);
      dir = 4'b1000;
      repeat (11) @(negedge clk);
      dir = 4'd0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (cur_x !== 8'd5 || cur_y !== 8'd3 || we !== 1'b0) begin
         n_fail++;
         $display("FAIL draw_position: got (%0d,%0d) we=%b, required (5,3) we=0", cur_x, cur_y, we);
      end
      rgb = 12'h743; draw = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         n_checks++;
         if (we !== (e == 3) || (e >= 3 && (waddr !== 16'h0305 || wdata !== 12'h743))) begin
            n_fail++;
            $display("FAIL draw_rise e=%0d: got we=%b waddr=%h wdata=%h, required we=%b 0305 743",
                     e, we, waddr, wdata, (e == 3));
         end
      end
      dir = 4'b1000;
      k = 0;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (we === 1'b1) begin
            n_checks++;
            if (waddr !== 16'h0306 + 16'(k) || wdata !== 12'h743) begin
               n_fail++;
               $display("FAIL draw_step k=%0d: got waddr=%h wdata=%h, required %h 743",
                        k, waddr, wdata, 16'h0306 + 16'(k));
            end
            k++;
         end
      end
      n_checks++;
      if (k != 4) begin
         n_fail++;
         $display("FAIL draw_step_count: got %0d writes, required 4", k);
      end
      dir = 4'd0; draw = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_wrap();
      int ey;
      do_reset();
      dir = 4'b0001;
      for (int e = 1; e <= 11; e++) begin
         @(negedge clk);
         ey = (!WRAP || e < 3) ? 0 : (e < 11) ? 255 : 254;
         n_checks++;
         if (cur_y !== 8'(ey) || cur_x !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_up e=%0d: got y=%0d x=%0d, required y=%0d x=0", e, cur_y, cur_x, ey);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_max_edge();
      do_reset();
      dir = 4'b1010; draw = 1'b1; rgb = 12'h5a5;
      for (int e = 1; e <= 1100; e++) begin
         @(negedge clk);
         n_checks++;
         if ({cur_x, cur_y, we, waddr, wdata} !== {m_x, m_y, m_we, m_waddr, m_wdata}) begin
            n_fail++;
            $display("FAIL max_edge e=%0d: got %h/%h/%b/%h/%h, required %h/%h/%b/%h/%h", e,
                     cur_x, cur_y, we, waddr, wdata, m_x, m_y, m_we, m_waddr, m_wdata);
         end
      end
      if (!WRAP) begin
         n_checks++;
         if (cur_x !== 8'd255 || cur_y !== 8'd255) begin
            n_fail++;
            $display("FAIL max_clamp: got (%0d,%0d), required (255,255)", cur_x, cur_y);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid_hold();
      do_reset();
      dir = 4'b1000;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cur_x !== 8'd0 || cur_y !== 8'd0 || we !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_hold_reset: got (%0d,%0d) we=%b, required (0,0) we=0", cur_x, cur_y, we);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         n_checks++;
         if (cur_x !== ((e >= 3) ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL mid_hold_repress e=%0d: got x=%0d, required %0d",
                     e, cur_x, (e >= 3) ? 1 : 0);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         n_checks++;
         if ({cur_x, cur_y, we, waddr, wdata} !== {m_x, m_y, m_we, m_waddr, m_wdata}) begin
            n_fail++;
            $display("FAIL random i=%0d: got %h/%h/%b/%h/%h, required %h/%h/%b/%h/%h", i,
                     cur_x, cur_y, we, waddr, wdata, m_x, m_y, m_we, m_waddr, m_wdata);
         end
         if ($urandom_range(0, 11) == 0) dir = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) draw = ~draw;
         rgb = 12'($urandom);
         rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hold_right();
      test_clamp();
      test_cancel();
      test_draw();
      test_wrap();
      test_max_edge();
      test_reset_mid_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
- Input stage of the VGA paint design. Takes the raw direction buttons, the draw switch and the colour switches.
- Moves a cursor over the framebuffer using a press/hold-repeat state machine.
- Issues single-cycle pixel write requests (address + colour) to the VRAM write port. The VGA scan-out stage consumes this port and the cursor position.

Parameters:
- XW, 8, cursor X width; framebuffer is 2^XW pixels wide.
- YW, 8, cursor Y width; framebuffer is 2^YW lines high.
- X_MAX, 255, largest legal X (≤ 2^XW-1).
- Y_MAX, 255, largest legal Y (≤ 2^YW-1).
- X_RST, 0, X after reset.
- Y_RST, 0, Y after reset.
- REPEAT_DLY, 8, clocks from first step to first auto-repeat step (≥2).
- STEP_DIV, 4, clocks between auto-repeat steps (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dir  in  4  raw buttons: [0] up (Y-1), [1] down (Y+1), [2] left (X-1), [3] right (X+1)
- draw  in  1  raw draw switch
- rgb  in  12  raw colour switches
- cur_x  out  XW  cursor X
- cur_y  out  YW  cursor Y
- we  out  1  VRAM write strobe, one clock per write
- waddr  out  XW+YW  VRAM write address = {cur_y, cur_x}
- wdata  out  12  VRAM write colour

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high; all flops clear immediately on rst=1.
- Reset values: cur_x=X_RST, cur_y=Y_RST, we=0, waddr={Y_RST,X_RST}, wdata=0, FSM=IDLE, synchronisers=0, counter=0.
- Synchronisation: dir, draw and rgb pass through 2-flop synchronisers (dir_s, draw_s, rgb_s). All logic below uses the synchronised values only.
- FSM states:
  - IDLE: dir_s==0. Leave on dir_s!=0: step, go to DELAY, cnt=0.
  - DELAY: cnt counts each clock. When cnt==REPEAT_DLY-1: step, go to REPEAT, cnt=0.
  - REPEAT: when cnt==STEP_DIV-1: step, cnt=0.
  - In DELAY or REPEAT, dir_s==0 returns to IDLE with no step.
  - In DELAY or REPEAT, dir_s changing to a different nonzero value counts as a new press: step that clock, go to DELAY, cnt=0.
- Step: cur_x/cur_y update on the clock edge where the step is taken.
  - Y: up-only gives Y-1; down-only gives Y+1; up and down together leave Y unchanged. X is handled the same way with left/right.
  - Saturating: X-1 at 0 stays 0; X+1 at X_MAX stays X_MAX. Same for Y with Y_MAX.
  - Diagonal moves (two axes at once) are legal.
- Latency: a change on dir appears in dir_s 2 edges later. cur_x/cur_y show the first step on the 3rd rising edge after the dir change.
- Write request: we=1 for exactly one clock, on the edge after any of:
  - (a) a step while draw_s=1, even if the step was clamped;
  - (b) a draw_s rising edge.
  - The same-cycle event is one write, not two.
  - waddr = {cur_y,cur_x} of the new position; wdata = rgb_s captured on the same edge.
  - waddr and wdata hold their values while we=0.
- No backpressure: VRAM write port always accepts.
- Reset mid-hold: cursor returns to (X_RST,Y_RST) and FSM to IDLE. A button still held after reset release counts as a fresh press: 3 edges to the first step.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: X-1 at 0 gives X_MAX, X+1 at X_MAX gives 0; Y wraps the same way with Y_MAX.
- Undefined: saturating behaviour as above.
- Write rules are identical in both builds.

Test Plan:
- Reset: rst=1 with dir=4'b1000, draw=1 → cur_x=0, cur_y=0, we=0, wdata=0 for as long as rst holds. After release, first step on the 3rd edge.
- Hold right from (0,0), defaults, draw=0:
  - cur_x=1 at edge 3;
  - cur_x=2 at edge 11;
  - cur_x then +1 every 4 clocks;
  - release → no further steps, FSM IDLE;
  - we stays 0 throughout.
- Clamp: from (0,0), dir=4'b0101 (up+left) held for 40 clocks → cur_x and cur_y stay 0. With draw=1, each step still pulses we once with waddr=16'h0000.
- Cancel: dir=4'b1010 (down+right) → both axes increment. dir=4'b0011 (up+down) → cur_y unchanged, and the change counts as a new press with timing restarting.
- Draw: at (5,3) with rgb=12'h743, draw 0→1 → one we pulse, waddr=16'h0305, wdata=12'h743. Then dir=4'b1000 held → one we per step, waddr 16'h0306, 16'h0307, … in sequence.
- With CURSOR_WRAP_EN: from (0,0), dir=4'b0001 (up) → cur_y=255 at edge 3, cur_y=254 at edge 11. The same stimulus without the macro leaves cur_y=0.
